// File: rtl/contrast_pixel_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : contrast_pixel_core_if
//  Brief    : Pixel stream bundle (valid/ready with sof/eol sideband).
//  Revision : 1.0  initial release
// ============================================================================
interface contrast_pixel_core_if #(
    parameter int NUM_CH = 3
);
    logic                  valid;
    logic                  ready;
    logic                  sof;
    logic                  eol;
    logic [8*NUM_CH-1:0]   pix;

    modport master (output valid, output sof, output eol, output pix, input ready);
    modport slave  (input valid, input sof, input eol, input pix, output ready);
endinterface
`default_nettype wire

// File: rtl/contrast_pixel_core.sv
`default_nettype none
// ============================================================================
//  Module   : contrast_pixel_core
//  Brief    : 3-stage shift/add contrast engine, out = clamp((pix-MID)*c+MID).
//  Revision : 1.0  initial release
// ============================================================================
module contrast_pixel_core #(
    parameter int NUM_CH = 3,
    parameter int MID    = 128
) (
    input  wire logic                   clk,
    input  wire logic                   resetN,
    input  wire logic [8:0]             cp_param,
    contrast_pixel_core_if.slave        in_if,
    contrast_pixel_core_if.master       out_if,
    output logic [8:0]                  active_cp
);

    // 4-bit shift term: 00 -> 0, 01 -> arithmetic right, 10 -> left, 11 -> 0
    function automatic logic signed [15:0] term(input logic [3:0] t,
                                                input logic signed [15:0] d);
        logic signed [15:0] res;
        case (t[3:2])
            2'b01:   res = d >>> t[1:0];
            2'b10:   res = d <<< t[1:0];
            default: res = '0;
        endcase
        return res;
    endfunction

    logic                w_adv;
    logic [8:0]          w_cp;
    logic [8:0]          r_active_cp;

    logic                r_v1, r_v2, r_v3;
    logic                r_sof1, r_sof2, r_sof3;
    logic                r_eol1, r_eol2, r_eol3;
    logic [8:0]          r_cp1;

    logic [8:0]          w_d    [NUM_CH];
    logic signed [15:0]  w_dfix [NUM_CH];
    logic signed [15:0]  w_sum  [NUM_CH];
    logic signed [15:0]  w_rnd  [NUM_CH];
    logic signed [15:0]  w_lvl  [NUM_CH];
    logic [7:0]          w_out  [NUM_CH];
    logic [8*NUM_CH-1:0] w_out_pix;

    logic signed [15:0]  r_dfix [NUM_CH];
    logic signed [15:0]  r_sum  [NUM_CH];
    logic [7:0]          r_out  [NUM_CH];

    // Every stage shares one advance, so a stalled output freezes the pipe
    assign w_adv = ~r_v3 | out_if.ready;
    assign w_cp  = (in_if.valid && in_if.sof) ? cp_param : r_active_cp;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_d[c]    = {1'b0, in_if.pix[8*c +: 8]} - 9'(MID);
            w_dfix[c] = {{4{w_d[c][8]}}, w_d[c], 3'b000};

            if (r_cp1[8])
                w_sum[c] = term(r_cp1[3:0], r_dfix[c]) - term(r_cp1[7:4], r_dfix[c]);
            else
                w_sum[c] = term(r_cp1[3:0], r_dfix[c]) + term(r_cp1[7:4], r_dfix[c]);

            w_rnd[c] = (r_sum[c] + 16'sd4) >>> 3;
            w_lvl[c] = w_rnd[c] + $signed(16'(MID));

            if (w_lvl[c][15])
                w_out[c] = 8'd0;
            else if (w_lvl[c] > 16'sd255)
                w_out[c] = 8'd255;
            else
                w_out[c] = w_lvl[c][7:0];
        end
    end

    always_comb begin
        w_out_pix = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_out_pix[8*c +: 8] = r_out[c];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_active_cp <= 9'h004;
            r_v1   <= 1'b0;  r_v2   <= 1'b0;  r_v3   <= 1'b0;
            r_sof1 <= 1'b0;  r_sof2 <= 1'b0;  r_sof3 <= 1'b0;
            r_eol1 <= 1'b0;  r_eol2 <= 1'b0;  r_eol3 <= 1'b0;
            r_cp1  <= 9'h004;
            for (int c = 0; c < NUM_CH; c++) begin
                r_dfix[c] <= '0;
                r_sum[c]  <= '0;
                r_out[c]  <= '0;
            end
        end else if (w_adv) begin
            if (in_if.valid && in_if.sof)
                r_active_cp <= cp_param;
            r_v1   <= in_if.valid;
            r_sof1 <= in_if.valid & in_if.sof;
            r_eol1 <= in_if.valid & in_if.eol;
            r_cp1  <= w_cp;
            r_v2   <= r_v1;
            r_sof2 <= r_sof1;
            r_eol2 <= r_eol1;
            r_v3   <= r_v2;
            r_sof3 <= r_sof2;
            r_eol3 <= r_eol2;
            for (int c = 0; c < NUM_CH; c++) begin
                r_dfix[c] <= w_dfix[c];
                r_sum[c]  <= w_sum[c];
                r_out[c]  <= w_out[c];
            end
        end
    end

    assign in_if.ready  = w_adv;
    assign out_if.valid = r_v3;
    assign out_if.sof   = r_sof3;
    assign out_if.eol   = r_eol3;
    assign out_if.pix   = w_out_pix;
    assign active_cp    = r_active_cp;

endmodule
`default_nettype wire

// File: tb/tb_contrast_pixel_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_contrast_pixel_core
//  Brief    : Directed scoreboard bench for contrast_pixel_core.
//  Revision : 1.0  initial release
// ============================================================================
module tb_contrast_pixel_core;
    localparam int NUM_CH = 3;

    typedef struct {
        logic [23:0] pix;
        logic        sof;
        logic        eol;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic [8:0] cp_param;
    logic [8:0] active_cp;

    contrast_pixel_core_if #(.NUM_CH(NUM_CH)) in_if ();
    contrast_pixel_core_if #(.NUM_CH(NUM_CH)) out_if ();

    contrast_pixel_core #(.NUM_CH(NUM_CH), .MID(128)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .cp_param  (cp_param),
        .in_if     (in_if),
        .out_if    (out_if),
        .active_cp (active_cp)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          lat_chk  = 1'b0;
    bit          rand_bp  = 1'b0;
    bit          hold_v   = 1'b0;
    logic [25:0] hold_val;
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] px(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    // Monitor: mid-cycle, so the sampled handshake is the one the next edge will use
    always @(negedge clk) begin
        if (!resetN) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("stall_hold", {6'd0, out_if.sof, out_if.eol, out_if.pix}, {6'd0, hold_val});
            if (out_if.valid && out_if.ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h expected none", out_if.pix);
                end else begin
                    e = sb.pop_front();
                    check("out_beat", {6'd0, out_if.sof, out_if.eol, out_if.pix}, {6'd0, e.sof, e.eol, e.pix});
                    if (lat_chk)
                        check("latency", cyc - e.cyc, 32'd3);
                end
            end
            hold_v   = out_if.valid && !out_if.ready;
            hold_val = {out_if.sof, out_if.eol, out_if.pix};
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) out_if.ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [23:0] p, input logic sof, input logic eol,
                        input logic [8:0] cp, input logic [23:0] exp);
        bit done = 1'b0;
        cp_param     = cp;
        in_if.pix    = p;
        in_if.sof    = sof;
        in_if.eol    = eol;
        in_if.valid  = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_if.ready) begin
                sb.push_back('{exp, sof, eol, cyc});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no in_ready expected accept");
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_if.valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN       = 1'b0;
        cp_param     = 9'h000;
        in_if.valid  = 1'b0;
        in_if.sof    = 1'b0;
        in_if.eol    = 1'b0;
        in_if.pix    = '0;
        out_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
        check("rst_out_pix", {8'd0, out_if.pix}, 32'd0);
        check("rst_sideband", {30'd0, out_if.sof, out_if.eol}, 32'd0);
        check("rst_active_cp", {23'd0, active_cp}, 32'h004);
        resetN = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_if.ready}, 32'd1);
        @(posedge clk);
        #1;

        // Identity code, back-to-back, latency measured
        lat_chk = 1'b1;
        send(px(0, 255, 8'h5A),   1, 0, 9'h004, px(0, 255, 8'h5A));
        send(px(77, 178, 8'h17),  0, 0, 9'h004, px(77, 178, 8'h17));
        send(px(128, 127, 8'hDA), 0, 0, 9'h004, px(128, 127, 8'hDA));
        send(px(200, 55, 8'h92),  0, 0, 9'h004, px(200, 55, 8'h92));
        send(px(255, 0, 8'hA5),   0, 1, 9'h004, px(255, 0, 8'hA5));
        drain();
        lat_chk = 1'b0;
        check("active_identity", {23'd0, active_cp}, 32'h004);

        // c = 2.0
        send(px(200, 100, 128), 1, 0, 9'h009, px(255, 72, 128));
        send(px(100, 128, 200), 0, 0, 9'h009, px(72, 128, 255));
        send(px(128, 128, 128), 0, 1, 9'h009, px(128, 128, 128));
        drain();
        check("active_x2", {23'd0, active_cp}, 32'h009);

        // c = 0.5, 0.875, 6.0, 0
        send(px(201, 128, 0),   1, 1, 9'h005, px(165, 128, 64));
        send(px(0, 128, 255),   1, 1, 9'h174, px(16, 128, 239));
        send(px(255, 255, 255), 1, 0, 9'h0A9, px(255, 255, 255));
        send(px(0, 0, 128),     0, 1, 9'h0A9, px(0, 0, 128));
        send(px(17, 200, 255),  1, 1, 9'h000, px(128, 128, 128));
        drain();
        check("active_zero", {23'd0, active_cp}, 32'h000);

        // Code change without sof must be ignored until the next frame
        send(px(10, 20, 30),    1, 0, 9'h004, px(10, 20, 30));
        send(px(200, 200, 200), 0, 1, 9'h009, px(200, 200, 200));
        drain();
        check("active_no_sof", {23'd0, active_cp}, 32'h004);
        send(px(200, 200, 200), 1, 1, 9'h009, px(255, 255, 255));
        drain();
        check("active_new_frame", {23'd0, active_cp}, 32'h009);

        // Random backpressure over a ramp
        rand_bp = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(px(8'(i * 4), 8'(255 - i), 8'(i)), i == 0, (i % 16) == 15, 9'h004,
                 px(8'(i * 4), 8'(255 - i), 8'(i)));
        end
        rand_bp = 1'b0;
        #1;
        out_if.ready = 1'b1;
        drain();

        // Reset with pixels in flight
        send(px(1, 2, 3), 1, 0, 9'h009, px(0, 0, 0));
        send(px(4, 5, 6), 0, 0, 9'h009, px(0, 0, 0));
        send(px(7, 8, 9), 0, 1, 9'h009, px(0, 0, 0));
        #1;
        resetN = 1'b0;
        sb.delete();
        #1;
        check("flush_out_valid", {31'd0, out_if.valid}, 32'd0);
        check("flush_active_cp", {23'd0, active_cp}, 32'h004);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(px(9, 8, 7), 1, 1, 9'h004, px(9, 8, 7));
        drain();
        lat_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
